// File: rtl/mult_sched_pkg.sv
// Shared defaults and tagged-result payload for the shared-multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned NUM_REQ_DEF        = 4;
  localparam int unsigned DATA_LEN_DEF       = 32;
  localparam int unsigned PIPELINE_STAGE_DEF = 2;
  localparam int unsigned RES_DEPTH_DEF      = 4;
  localparam int unsigned ID_W_DEF           = $clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]     id;
    logic [DATA_LEN_DEF-1:0] result;
  } tagged_result_t;

endpackage

// File: rtl/mult_sched_fifo.sv
// Result FIFO: power-of-two depth, wrapping pointers, synchronous clear, occupancy count.
module mult_sched_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are qualified by a non-zero count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one external pipelined multiplier among NUM_REQ requesters,
// with credit-based admission so the in-order result FIFO can never overflow.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
  parameter int unsigned DATA_LEN       = DATA_LEN_DEF,
  parameter int unsigned PIPELINE_STAGE = PIPELINE_STAGE_DEF,
  parameter int unsigned RES_DEPTH      = RES_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_b,
  output logic [DATA_LEN-1:0]         mul_a,
  output logic [DATA_LEN-1:0]         mul_b,
  input  logic [DATA_LEN-1:0]         mul_result,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_LEN-1:0]         rsp_result,
  input  logic                        flush,
  output logic                        busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = ID_W + DATA_LEN;
  localparam int unsigned LAST  = PIPELINE_STAGE;

  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_LEN-1:0] mul_a_q, mul_a_d;
  logic [DATA_LEN-1:0] mul_b_q, mul_b_d;
  logic [LAST:0]       tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]     tag_id_q [LAST+1];
  logic [ID_W-1:0]     tag_id_d [LAST+1];
  logic [CNT_W-1:0]    in_flight_q, in_flight_d;

  logic [DATA_LEN-1:0] op_a [NUM_REQ];
  logic [DATA_LEN-1:0] op_b [NUM_REQ];
  logic [ID_W-1:0]     grant_idx;
  logic                grant_found;
  logic                credit_ok;
  logic                issue;
  logic                push;
  logic                pop;
  logic [ENT_W-1:0]    pop_data;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_a[i] = req_a[i*DATA_LEN +: DATA_LEN];
      op_b[i] = req_b[i*DATA_LEN +: DATA_LEN];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // Credits cover both ops still in the multiplier and results waiting in the FIFO.
  assign credit_ok = (SUM_W'(in_flight_q) + SUM_W'(fifo_count)) < SUM_W'(RES_DEPTH);
  assign issue     = grant_found && credit_ok && !flush && reset_n;
  assign req_ready = issue ? (NUM_REQ'(1) << grant_idx) : '0;
  assign push      = tag_vld_q[LAST];
  assign pop       = !fifo_empty && rsp_ready;

  always_comb begin
    int unsigned nxt;
    rr_ptr_d    = rr_ptr_q;
    mul_a_d     = '0;
    mul_b_d     = '0;
    in_flight_d = in_flight_q;
    tag_vld_d   = '0;
    for (int unsigned k = 0; k <= LAST; k++) tag_id_d[k] = '0;
    nxt = 32'(grant_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;

    if (flush) begin
      rr_ptr_d    = '0;
      in_flight_d = '0;
    end else begin
      tag_vld_d[0] = issue;
      tag_id_d[0]  = grant_idx;
      for (int unsigned k = 1; k <= LAST; k++) begin
        tag_vld_d[k] = tag_vld_q[k-1];
        tag_id_d[k]  = tag_id_q[k-1];
      end
      if (issue) begin
        rr_ptr_d = ID_W'(nxt);
        mul_a_d  = op_a[grant_idx];
        mul_b_d  = op_b[grant_idx];
      end
      if (issue && !push)      in_flight_d = in_flight_q + CNT_W'(1);
      else if (!issue && push) in_flight_d = in_flight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      in_flight_q <= '0;
      for (int unsigned k = 0; k <= LAST; k++) tag_id_q[k] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= tag_vld_d;
      in_flight_q <= in_flight_d;
      for (int unsigned k = 0; k <= LAST; k++) tag_id_q[k] <= tag_id_d[k];
    end
  end

  mult_sched_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (push),
    .push_data ({tag_id_q[LAST], mul_result}),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = !fifo_empty;
  assign rsp_id     = fifo_empty ? '0 : pop_data[ENT_W-1 -: ID_W];
  assign rsp_result = fifo_empty ? '0 : pop_data[DATA_LEN-1:0];
  assign busy       = (in_flight_q != '0) || (fifo_count != '0);

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter DATA_LEN, default 32, operand/result width.
REQ-003 SHALL have parameter PIPELINE_STAGE, default 2, multiplier latency in cycles.
REQ-004 SHALL have parameter RES_DEPTH, default 4, result FIFO depth (power of two, >= 2).
REQ-005 SHALL have ports: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: req_valid  in  NUM_REQ  per-requester request valid; req_ready  out  NUM_REQ  per-requester accept.
REQ-007 SHALL have ports: req_a, req_b  in  NUM_REQ*DATA_LEN  packed operands, requester i at slice [i*DATA_LEN +: DATA_LEN].
REQ-008 SHALL have ports: mul_a, mul_b  out  DATA_LEN  multiplier operands; mul_result  in  DATA_LEN  multiplier product.
REQ-009 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  $clog2(NUM_REQ)  originating requester; rsp_result  out  DATA_LEN.
REQ-010 SHALL have ports: flush  in  1  synchronous discard of all in-flight work; busy  out  1  any op in flight or queued.

Function
REQ-011 Arbitration SHALL be round-robin: grant the lowest index >= rr_ptr with req_valid set, wrapping; rr_ptr SHALL become grant+1 (mod NUM_REQ) after each accepted request.
REQ-012 An issue SHALL occur only when (in_flight + fifo_count) < RES_DEPTH and flush is low; req_ready SHALL be combinational, one-hot on the granted index only when issuing, else all zero.
REQ-013 Accepted request in cycle I SHALL drive mul_a/mul_b (registered) in cycle I+1; in non-issue cycles mul_a/mul_b SHALL be zero.
REQ-014 mul_result for operands presented in cycle C SHALL be treated as valid in cycle C+PIPELINE_STAGE; a valid/id shift register of PIPELINE_STAGE+1 entries SHALL track each op.
REQ-015 The product SHALL be pushed with its id into the result FIFO at the end of cycle I+1+PIPELINE_STAGE; rsp_valid SHALL assert in cycle I+2+PIPELINE_STAGE when the FIFO was empty (latency 4 at defaults).
REQ-016 rsp_valid SHALL equal FIFO non-empty; a pop SHALL occur when rsp_valid && rsp_ready; rsp_id/rsp_result SHALL hold stable while rsp_valid && !rsp_ready.
REQ-017 Simultaneous push and pop SHALL leave fifo_count unchanged; credit rule (REQ-012) SHALL make FIFO overflow impossible; pointers wrap modulo RES_DEPTH.
REQ-018 Credit released by a pop SHALL be usable for issue in the next cycle (no same-cycle bypass).
REQ-019 Results SHALL return in issue order; no reordering by requester.
REQ-020 flush SHALL, at the clock edge, clear the tag pipeline, FIFO, in_flight count and rr_ptr to 0; no request is accepted in the flush cycle; products of flushed ops SHALL never appear on rsp.
REQ-021 busy SHALL be high whenever in_flight != 0 or fifo_count != 0.

Reset
REQ-022 reset_n low SHALL asynchronously clear: req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, rr_ptr=0, all counters and tag valids 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight and queued results; first accept after deassert SHALL be no earlier than the first rising edge with reset_n high.

Structure
REQ-024 NUM_REQ, DATA_LEN, PIPELINE_STAGE defaults and a tagged-result struct (id, result) SHALL live in shared package mult_sched_pkg.
REQ-025 The result FIFO SHALL be a separate sub-module, mult_sched_fifo (synchronous, same clk/reset_n, count output); the multiplier itself SHALL remain outside this block.

Verification
REQ-026 Single op: requester 2 sends a=7,b=6, rsp_ready=1 -> rsp_valid 4 cycles after accept, rsp_id=2, rsp_result=42.
REQ-027 Contention: all 4 valid continuously, a=i+1,b=10 -> accept order 0,1,2,3,0..., results 10,20,30,40 in that order, one per cycle.
REQ-028 Backpressure: rsp_ready=0, all requesters valid -> exactly 4 accepts then req_ready all zero; raising rsp_ready for one cycle -> exactly one further accept next cycle.
REQ-029 Flush: 3 ops in flight, pulse flush -> none of the 3 appears on rsp, busy=0 next cycle, next request from requester 1 accepted with rr_ptr=0 and returns correct product.
REQ-030 Wrap/overflow: a=32'hFFFF_FFFF,b=2 -> rsp_result=32'hFFFF_FFFE (low DATA_LEN bits); 20 back-to-back ops verify FIFO pointer wrap with no loss.
REQ-031 Async reset: assert reset_n low mid-stream between edges -> all outputs zero immediately; after release, no stale rsp_valid.
